shot_sequencer: RTL and testbench
=================================

Name: shot_sequencer

Overview:
- Upstream stage of pattern_gen. Conditions the raw gun trigger and light-sensor inputs, then sequences a shot as one or more black frames followed by one or more target-flash frames.
- All phases are aligned to the VGA frame-start pulse.
- Drives flash_black/flash_target into pattern_gen, judges hit/miss from the sensor, and tracks remaining ammo.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable clk cycles needed to accept a new trigger level (10 ms at 25 MHz).
- BLACK_FRAMES, 1, number of full frames in the black phase.
- TARGET_FRAMES, 1, number of full frames in the target-flash phase.
- COOLDOWN_FRAMES, 15, frames after a shot during which presses are ignored.
- SHOTS, 3, ammo loaded at reset and on reload.

Ports:
- clk  in  1  pixel clock from the PLL.
- reset_n  in  1  asynchronous, active-low reset.
- trigger  in  1  raw gun trigger, active-high, asynchronous to clk.
- sensor  in  1  raw light sensor, active-high when bright, asynchronous.
- frame_start  in  1  one-cycle pulse from the VGA timing block at the start of each frame.
- reload  in  1  one-cycle request to refill ammo.
- flash_black  out  1  pattern_gen renders an all-black frame.
- flash_target  out  1  pattern_gen renders the white target-box frame.
- hit  out  1  one-cycle pulse, shot judged a hit.
- miss  out  1  one-cycle pulse, shot judged a miss.
- busy  out  1  high in any state other than IDLE.
- shots_left  out  $clog2(SHOTS+1)  remaining ammo.

Behaviour:
- Reset values: every output 0 except shots_left=SHOTS. Synchronisers, debounce counter and the debounced level are 0. State is IDLE.
- Input conditioning:
  - trigger and sensor each pass through a 2-FF synchroniser.
  - Debounce: counter increments while the synced trigger differs from the debounced level, and clears when they match. When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - press = rising edge of the debounced level (one cycle).
- State machine, all outputs registered:
  - IDLE:
    - press with shots_left>0 -> ARM, shots_left decrements by 1.
    - press with shots_left==0 is ignored; no pulse is generated.
    - reload -> shots_left=SHOTS.
    - If reload and press occur in the same cycle, reload takes priority and the press is dropped.
  - ARM: wait for frame_start, then -> BLACK with frame counter=0. A press and a frame_start in the same IDLE cycle still enters ARM, so BLACK starts on the next frame_start.
  - BLACK:
    - flash_black=1, starting the cycle after the frame_start that entered BLACK.
    - A synced sensor high at any cycle sets black_seen.
    - Each frame_start increments the counter. At the BLACK_FRAMES-th frame_start -> TARGET, counter=0, flash_black=0 and flash_target=1 on the following cycle.
  - TARGET:
    - A synced sensor high sets target_seen.
    - At the TARGET_FRAMES-th frame_start -> JUDGE.
  - JUDGE (one cycle):
    - hit=1 if target_seen && !black_seen, otherwise miss=1. A bright room is therefore a miss.
    - Clear both seen flags -> COOLDOWN, counter=0, flash_target=0.
  - COOLDOWN: presses ignored. At the COOLDOWN_FRAMES-th frame_start -> IDLE. COOLDOWN_FRAMES=0 goes directly to IDLE.
- Exclusivity: flash_black and flash_target are never both 1. hit and miss are never both 1.
- Reload outside IDLE is ignored, with no queuing.
- shots_left saturates at 0 and never wraps.
- An asynchronous reset mid-shot immediately clears the flash outputs and pulses, and restores shots_left=SHOTS.

Test Plan:
- Debounce (DEBOUNCE_CYCLES=8): trigger glitches high for 5 cycles -> no press, busy stays 0. Trigger held 20 cycles -> exactly one press, and busy rises 8 debounce cycles plus 2 sync cycles plus 1 later.
- Hit shot (BLACK_FRAMES=1, TARGET_FRAMES=1): press, then sensor driven high only while flash_target=1 -> flash_black lasts exactly one frame, flash_target exactly one frame, then a single hit pulse, shots_left 3->2.
- Bright room: sensor held high for the whole shot -> miss pulse only, never hit.
- Ammo exhaustion: three complete shots leave shots_left=0. A fourth press produces no flash and busy stays 0. reload in IDLE -> shots_left=3.
- Cooldown and simultaneity (COOLDOWN_FRAMES=2): a press during COOLDOWN is ignored. A press coincident with frame_start in IDLE delays flash_black to the next frame_start.
- Reset mid-TARGET: reset_n pulled low -> flash_target=0 immediately, shots_left=3, state IDLE, and no hit/miss pulse is emitted.

Source files
------------

// File: rtl/shot_sequencer.sv
// Light-gun shot sequencer: conditions trigger/sensor, steps black and target
// flash phases on frame boundaries, judges hit or miss and tracks ammo.
module shot_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLACK_FRAMES    = 1,
  parameter int TARGET_FRAMES   = 1,
  parameter int COOLDOWN_FRAMES = 15,
  parameter int SHOTS           = 3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         trigger,
  input  logic                         sensor,
  input  logic                         frame_start,
  input  logic                         reload,
  output logic                         flash_black,
  output logic                         flash_target,
  output logic                         hit,
  output logic                         miss,
  output logic                         busy,
  output logic [$clog2(SHOTS+1)-1:0]   shots_left,
  output logic [2:0]                   dbg_state
);

  localparam int SW    = $clog2(SHOTS + 1);
  localparam int DW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int MAXF0 = (BLACK_FRAMES > TARGET_FRAMES) ? BLACK_FRAMES : TARGET_FRAMES;
  localparam int MAXF  = (COOLDOWN_FRAMES > MAXF0) ? COOLDOWN_FRAMES : MAXF0;
  localparam int FW    = $clog2(MAXF + 1);

  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [FW-1:0] BLACK_LAST  = FW'(BLACK_FRAMES - 1);
  localparam logic [FW-1:0] TARGET_LAST = FW'(TARGET_FRAMES - 1);
  localparam logic [FW-1:0] COOL_LAST   = FW'(COOLDOWN_FRAMES - 1);
  localparam logic [SW-1:0] SHOTS_FULL  = SW'(SHOTS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARM      = 3'd1,
    BLACK    = 3'd2,
    TARGET   = 3'd3,
    JUDGE    = 3'd4,
    COOLDOWN = 3'd5
  } state_t;

  logic          trig_s1_q, trig_s2_q, sens_s1_q, sens_s2_q;
  logic [DW-1:0] deb_cnt_q;
  logic          deb_q, deb_prev_q;
  logic          press;

  state_t        state_q;
  logic [FW-1:0] frame_cnt_q;
  logic [SW-1:0] shots_q;
  logic          black_seen_q, target_seen_q;
  logic          flash_black_q, flash_target_q, hit_q, miss_q, busy_q;

  // The debounced level only moves after DEBOUNCE_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_s1_q  <= 1'b0;
      trig_s2_q  <= 1'b0;
      sens_s1_q  <= 1'b0;
      sens_s2_q  <= 1'b0;
      deb_cnt_q  <= '0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
    end else begin
      trig_s1_q  <= trigger;
      trig_s2_q  <= trig_s1_q;
      sens_s1_q  <= sensor;
      sens_s2_q  <= sens_s1_q;
      deb_prev_q <= deb_q;
      if (trig_s2_q == deb_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        deb_q     <= trig_s2_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= deb_cnt_q + 1'b1;
      end
    end
  end

  assign press = deb_q & ~deb_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      frame_cnt_q    <= '0;
      shots_q        <= SHOTS_FULL;
      black_seen_q   <= 1'b0;
      target_seen_q  <= 1'b0;
      flash_black_q  <= 1'b0;
      flash_target_q <= 1'b0;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // Reload wins over a coincident press; an empty gun drops the press.
          if (reload) begin
            shots_q <= SHOTS_FULL;
          end else if (press && (shots_q != '0)) begin
            shots_q <= shots_q - 1'b1;
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        ARM: begin
          if (frame_start) begin
            state_q       <= BLACK;
            frame_cnt_q   <= '0;
            flash_black_q <= 1'b1;
          end
        end
        BLACK: begin
          if (sens_s2_q) black_seen_q <= 1'b1;
          if (frame_start) begin
            if (frame_cnt_q == BLACK_LAST) begin
              state_q        <= TARGET;
              frame_cnt_q    <= '0;
              flash_black_q  <= 1'b0;
              flash_target_q <= 1'b1;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        TARGET: begin
          if (sens_s2_q) target_seen_q <= 1'b1;
          if (frame_start) begin
            if (frame_cnt_q == TARGET_LAST) begin
              state_q        <= JUDGE;
              frame_cnt_q    <= '0;
              flash_target_q <= 1'b0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        JUDGE: begin
          // Light during the black frame means the sensor sees the room, not the box.
          hit_q         <= target_seen_q && !black_seen_q;
          miss_q        <= !(target_seen_q && !black_seen_q);
          black_seen_q  <= 1'b0;
          target_seen_q <= 1'b0;
          frame_cnt_q   <= '0;
          if (COOLDOWN_FRAMES == 0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (frame_start) begin
            if (frame_cnt_q == COOL_LAST) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              frame_cnt_q <= frame_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign flash_black  = flash_black_q;
  assign flash_target = flash_target_q;
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign busy         = busy_q;
  assign shots_left   = shots_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_shot_sequencer.sv
// Bench for shot_sequencer: scenario tasks with a shot-outcome/ammo model,
// frame_start produced by a free-running frame counter of FL cycles.
module tb_shot_sequencer;

  localparam int DC = 8;
  localparam int BF = 1;
  localparam int TF = 1;
  localparam int CF = 2;
  localparam int SH = 3;
  localparam int FL = 24;
  localparam int SHOT_BUDGET = 8 * FL + 60;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       trigger = 1'b0;
  logic       sensor = 1'b0;
  logic       frame_start = 1'b0;
  logic       reload = 1'b0;
  logic       flash_black, flash_target, hit, miss, busy;
  logic [1:0] shots_left;
  logic [2:0] dbg_state;

  int chk_cnt = 0;
  int err_cnt = 0;
  int fphase = 0;
  int exp_shots = SH;
  logic [1:0] exp_q[$];

  shot_sequencer #(
    .DEBOUNCE_CYCLES(DC), .BLACK_FRAMES(BF), .TARGET_FRAMES(TF),
    .COOLDOWN_FRAMES(CF), .SHOTS(SH)
  ) dut (
    .clk(clk), .reset_n(reset_n), .trigger(trigger), .sensor(sensor),
    .frame_start(frame_start), .reload(reload), .flash_black(flash_black),
    .flash_target(flash_target), .hit(hit), .miss(miss), .busy(busy),
    .shots_left(shots_left), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      fphase = (fphase + 1) % FL;
      frame_start = (fphase == 0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; trigger = 1'b0; sensor = 1'b0; reload = 1'b0;
    repeat (3) tick();
    chk_cnt++; if (flash_black !== 1'b0) begin err_cnt++; $display("FAIL reset_flash_black: got %b expected 0", flash_black); end
    chk_cnt++; if (flash_target !== 1'b0) begin err_cnt++; $display("FAIL reset_flash_target: got %b expected 0", flash_target); end
    chk_cnt++; if (hit !== 1'b0 || miss !== 1'b0) begin err_cnt++; $display("FAIL reset_pulses: got hit=%b miss=%b expected 0 0", hit, miss); end
    chk_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
    chk_cnt++; if (shots_left !== 2'(SH)) begin err_cnt++; $display("FAIL reset_shots: got %0d expected %0d", shots_left, SH); end
    chk_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    reset_n = 1'b1;
    repeat (2) tick();
    exp_shots = SH;
  endtask

  task automatic do_reload(input string tag);
    reload = 1'b1; tick(); reload = 1'b0; tick();
    exp_shots = SH;
    chk_cnt++; if (shots_left !== 2'(exp_shots)) begin err_cnt++; $display("FAIL %s_reload: got %0d expected %0d", tag, shots_left, exp_shots); end
  endtask

  // mode: 0 dark, 1 sensor follows the target flash, 2 sensor follows the black flash, 3 bright room
  task automatic do_shot(input int mode, input int reload_at, input string tag);
    int nb = 0, nt = 0, nh = 0, nm = 0, bad = 0;
    bit rose = 0, done = 0;
    logic [1:0] exp;
    exp_shots--;
    exp_q.push_back((mode == 1) ? 2'b10 : 2'b01);
    if (mode == 3) sensor = 1'b1;
    trigger = 1'b1;
    for (int n = 0; n < SHOT_BUDGET && !done; n++) begin
      tick();
      if (n == 13) trigger = 1'b0;
      reload = (n == reload_at);
      case (mode)
        1: sensor = flash_target;
        2: sensor = flash_black;
        3: sensor = 1'b1;
        default: sensor = 1'b0;
      endcase
      nb += int'(flash_black);
      nt += int'(flash_target);
      nh += int'(hit);
      nm += int'(miss);
      bad += int'((flash_black && flash_target) || (hit && miss));
      if (busy) rose = 1;
      else if (rose) done = 1;
    end
    trigger = 1'b0; sensor = 1'b0; reload = 1'b0;
    exp = exp_q.pop_front();
    chk_cnt++; if (!done) begin err_cnt++; $display("FAIL %s_complete: got rose=%0d done=%0d expected 1 1", tag, rose, done); end
    chk_cnt++; if (nb != FL * BF) begin err_cnt++; $display("FAIL %s_black_len: got %0d expected %0d", tag, nb, FL * BF); end
    chk_cnt++; if (nt != FL * TF) begin err_cnt++; $display("FAIL %s_target_len: got %0d expected %0d", tag, nt, FL * TF); end
    chk_cnt++; if (nh != int'(exp[1]) || nm != int'(exp[0])) begin err_cnt++; $display("FAIL %s_judge: got hits=%0d misses=%0d expected %0d %0d", tag, nh, nm, exp[1], exp[0]); end
    chk_cnt++; if (bad != 0) begin err_cnt++; $display("FAIL %s_exclusive: got %0d overlaps expected 0", tag, bad); end
    chk_cnt++; if (shots_left !== 2'(exp_shots)) begin err_cnt++; $display("FAIL %s_shots: got %0d expected %0d", tag, shots_left, exp_shots); end
  endtask

  task automatic test_debounce();
    int busy_hi = 0, first = -1, nev = 0, busy_after = 0;
    trigger = 1'b1; repeat (5) tick(); trigger = 1'b0;
    repeat (30) begin tick(); busy_hi += int'(busy); end
    chk_cnt++; if (busy_hi != 0) begin err_cnt++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_hi); end
    trigger = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 20) trigger = 1'b0;
      if (busy && first < 0) first = n;
      nev += int'(hit) + int'(miss);
    end
    for (int n = 0; n < SHOT_BUDGET && busy; n++) begin
      tick();
      nev += int'(hit) + int'(miss);
    end
    repeat (40) begin tick(); busy_after += int'(busy); nev += int'(hit) + int'(miss); end
    exp_shots--;
    chk_cnt++; if (first != DC + 2 + 1) begin err_cnt++; $display("FAIL debounce_latency: got %0d expected %0d", first, DC + 3); end
    chk_cnt++; if (nev != 1) begin err_cnt++; $display("FAIL debounce_single_shot: got %0d judgements expected 1", nev); end
    chk_cnt++; if (busy_after != 0) begin err_cnt++; $display("FAIL debounce_no_repress: got %0d busy cycles expected 0", busy_after); end
    chk_cnt++; if (shots_left !== 2'(exp_shots)) begin err_cnt++; $display("FAIL debounce_shots: got %0d expected %0d", shots_left, exp_shots); end
  endtask

  task automatic test_reload_priority();
    int busy_hi = 0;
    trigger = 1'b1;
    repeat (10) tick();
    reload = 1'b1; tick(); reload = 1'b0;
    busy_hi += int'(busy);
    for (int n = 0; n < 40; n++) begin
      tick();
      if (n == 3) trigger = 1'b0;
      busy_hi += int'(busy);
    end
    exp_shots = SH;
    chk_cnt++; if (busy_hi != 0) begin err_cnt++; $display("FAIL reload_priority_busy: got %0d busy cycles expected 0", busy_hi); end
    chk_cnt++; if (shots_left !== 2'(exp_shots)) begin err_cnt++; $display("FAIL reload_priority_shots: got %0d expected %0d", shots_left, exp_shots); end
  endtask

  task automatic test_ammo();
    int activity = 0;
    while (exp_shots > 0) do_shot(int'($urandom_range(0, 3)), -1, "drain");
    trigger = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (n == 13) trigger = 1'b0;
      activity += int'(busy) + int'(flash_black) + int'(flash_target) + int'(hit) + int'(miss);
    end
    chk_cnt++; if (activity != 0) begin err_cnt++; $display("FAIL empty_press: got %0d active cycles expected 0", activity); end
    chk_cnt++; if (shots_left !== 2'd0) begin err_cnt++; $display("FAIL empty_shots: got %0d expected 0", shots_left); end
    do_reload("ammo");
  endtask

  task automatic test_cooldown();
    int nev = 0, busy_after = 0;
    bit rearmed = 0, rose = 0, done = 0;
    if (exp_shots == 0) do_reload("cooldown");
    exp_shots--;
    trigger = 1'b1;
    for (int n = 0; n < SHOT_BUDGET && !done; n++) begin
      tick();
      if (n == 13) trigger = 1'b0;
      if ((hit || miss) && !rearmed) begin trigger = 1'b1; rearmed = 1; end
      nev += int'(hit) + int'(miss);
      if (busy) rose = 1;
      else if (rose) done = 1;
    end
    repeat (60) begin tick(); busy_after += int'(busy); end
    trigger = 1'b0;
    repeat (20) tick();
    chk_cnt++; if (!done || !rearmed) begin err_cnt++; $display("FAIL cooldown_complete: got done=%0d rearmed=%0d expected 1 1", done, rearmed); end
    chk_cnt++; if (nev != 1) begin err_cnt++; $display("FAIL cooldown_judge: got %0d judgements expected 1", nev); end
    chk_cnt++; if (busy_after != 0) begin err_cnt++; $display("FAIL cooldown_press_ignored: got %0d busy cycles expected 0", busy_after); end
    chk_cnt++; if (shots_left !== 2'(exp_shots)) begin err_cnt++; $display("FAIL cooldown_shots: got %0d expected %0d", shots_left, exp_shots); end
  endtask

  task automatic test_simultaneous();
    int waited = 0, first_busy = -1, first_fb = -1;
    bit rose = 0, done = 0;
    if (exp_shots == 0) do_reload("simul");
    @(posedge clk); #2;
    while (fphase != FL - 10 && waited <= FL) begin @(posedge clk); #2; waited++; end
    exp_shots--;
    trigger = 1'b1;
    for (int n = 1; n < SHOT_BUDGET && !done; n++) begin
      tick();
      if (n == 14) trigger = 1'b0;
      if (busy && first_busy < 0) first_busy = n;
      if (flash_black && first_fb < 0) first_fb = n;
      if (busy) rose = 1;
      else if (rose) done = 1;
    end
    chk_cnt++; if (waited > FL || !done) begin err_cnt++; $display("FAIL simul_setup: got waited=%0d done=%0d expected <=%0d 1", waited, done, FL); end
    chk_cnt++; if (first_busy != DC + 3) begin err_cnt++; $display("FAIL simul_busy: got %0d expected %0d", first_busy, DC + 3); end
    chk_cnt++; if (first_fb != DC + 3 + FL) begin err_cnt++; $display("FAIL simul_black_delay: got %0d expected %0d", first_fb, DC + 3 + FL); end
    chk_cnt++; if (shots_left !== 2'(exp_shots)) begin err_cnt++; $display("FAIL simul_shots: got %0d expected %0d", shots_left, exp_shots); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      if (exp_shots == 0) do_reload("b2b");
      do_shot(int'($urandom_range(0, 3)), -1, "b2b");
    end
  endtask

  task automatic test_reset_mid_target();
    int activity = 0;
    bit seen = 0;
    if (exp_shots == 0) do_reload("rst");
    trigger = 1'b1;
    for (int n = 0; n < SHOT_BUDGET && !seen; n++) begin
      tick();
      if (n == 13) trigger = 1'b0;
      if (flash_target) seen = 1;
    end
    trigger = 1'b0;
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    exp_shots = SH;
    chk_cnt++; if (!seen) begin err_cnt++; $display("FAIL rst_reach_target: got 0 expected 1"); end
    chk_cnt++; if (flash_target !== 1'b0 || flash_black !== 1'b0) begin err_cnt++; $display("FAIL rst_flash: got black=%b target=%b expected 0 0", flash_black, flash_target); end
    chk_cnt++; if (hit !== 1'b0 || miss !== 1'b0 || busy !== 1'b0) begin err_cnt++; $display("FAIL rst_outputs: got hit=%b miss=%b busy=%b expected 0 0 0", hit, miss, busy); end
    chk_cnt++; if (shots_left !== 2'(exp_shots)) begin err_cnt++; $display("FAIL rst_shots: got %0d expected %0d", shots_left, exp_shots); end
    chk_cnt++; if (dbg_state !== 3'd0) begin err_cnt++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3 * FL) begin
      tick();
      activity += int'(busy) + int'(flash_black) + int'(flash_target) + int'(hit) + int'(miss);
    end
    chk_cnt++; if (activity != 0) begin err_cnt++; $display("FAIL rst_quiet_after: got %0d active cycles expected 0", activity); end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_reload_priority();
    do_shot(1, -1, "hit");
    do_shot(3, -1, "bright");
    test_ammo();
    do_shot(0, 40, "reload_busy");
    test_cooldown();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_target();
    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule
